// File: rtl/chunked_seq_adder_pkg.sv
// rtl/chunked_seq_adder_pkg.sv - shared types and helpers for the chunked sequential adder
package chunked_seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width; at least one bit even when there is a single chunk
    function automatic int idx_width(input int n);
        return $clog2((n > 2) ? n : 2);
    endfunction

endpackage

// File: rtl/chunked_seq_adder_slice.sv
// rtl/chunked_seq_adder_slice.sv - combinational CHUNK-bit ripple-carry slice
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/sub reusing one ripple slice per chunk
import chunked_seq_adder_pkg::*;

module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = idx_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH:0]   res_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co;

    // Pick chunk k out of the captured operands for the shared slice
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a   (a_chunk),
        .b   (b_chunk),
        .ci  (carry),
        .sum (s_chunk),
        .co  (co)
    );

    assign sum = res_q;

    // Control FSM plus operand, carry, index and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            res_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtraction is a + ~b + 1: invert b here, seed the carry with sub
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{sub}};
                        carry    <= sub;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (k == KW'(i)) begin
                            res_q[i*CHUNK +: CHUNK] <= s_chunk;
                        end
                    end
                    carry <= co;
                    k     <= k + KW'(1);
                    if (k == K_LAST) begin
                        res_q[WIDTH] <= co;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - scoreboard bench for chunked_seq_adder
module tb_chunked_seq_adder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] sum;

    logic        in_valid8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        sub8;
    logic        ir8a, ov8a, ir8b, ov8b;
    logic [8:0]  s8a;
    logic [8:0]  s8b;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];
    int          acc_cnt = 0;
    logic        prev_ready = 1'b1;
    bit          hold_valid = 0;
    bit          scramble = 1;

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
    );

    chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut_w8c8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir8a),
        .a(a8), .b(b8), .sub(sub8), .out_valid(ov8a), .out_ready(1'b1), .sum(s8a)
    );

    chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) dut_w8c1 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir8b),
        .a(a8), .b(b8), .sub(sub8), .out_valid(ov8b), .out_ready(1'b1), .sum(s8b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        return s ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        return s ? ({1'b0, x} + {1'b0, ~y} + 9'd1) : ({1'b0, x} + {1'b0, y});
    endfunction

    // Scoreboard: compare on every result handshake, count acceptances
    always @(negedge clk) begin
        if (!reset && prev_ready && !in_ready) acc_cnt++;
        prev_ready = in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_result", 32'(exp_q.size()), 32'd1);
            else chk("sum", 32'(sum), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                         input logic [16:0] e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (!hold_valid) in_valid = 1'b0;
            if (scramble) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                sub = 1'($urandom);
            end
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                      input logic [16:0] e);
        int lat;
        issue(ta, tb_v, ts, e);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input logic [8:0] e);
        int n = 0;
        int la = 0;
        int lb = 0;
        @(posedge clk);
        #1;
        a8        = ta;
        b8        = tb_v;
        sub8      = ts;
        in_valid8 = 1'b1;
        while ((la == 0 || lb == 0) && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            in_valid8 = 1'b0;
            a8        = 8'($urandom);
            b8        = 8'($urandom);
            sub8      = 1'($urandom);
            @(negedge clk);
            if (ov8a && la == 0) begin
                la = n;
                chk("w8c8_sum", 32'(s8a), 32'(e));
            end
            if (ov8b && lb == 0) begin
                lb = n;
                chk("w8c1_sum", 32'(s8b), 32'(e));
            end
        end
        chk("w8c8_latency", 32'(la), 32'd2);
        chk("w8c1_latency", 32'(lb), 32'd9);
    endtask

    initial begin
        int          lat;
        int          acc0;
        int          seen;
        logic [15:0] ra, rb;
        logic        rs;
        logic [7:0]  r8a, r8b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        a8        = '0;
        b8        = '0;
        sub8      = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        op(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        op(16'h0005, 16'h0007, 1'b1, 17'h0FFFE);
        op(16'h0007, 16'h0005, 1'b1, 17'h10002);

        // Backpressure: three DONE cycles with out_ready low, handshake on the fourth
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, 17'h05555);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            chk("bp_sum_hold", 32'(sum), 32'h05555);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the second RUN cycle discards the operation
        issue(16'h1234, 16'h1111, 1'b0, 17'h02345);
        exp_q.delete();
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_result", 32'(seen), 32'd0);
        op(16'h0001, 16'h0001, 1'b0, 17'h00002);

        // in_valid held high through RUN and DONE: one acceptance only
        hold_valid = 1;
        scramble   = 0;
        acc0       = acc_cnt;
        issue(16'h00AA, 16'h0055, 1'b0, 17'h000FF);
        wait_valid(lat);
        chk("hold_latency", 32'(lat), 32'd5);
        @(posedge clk);
        #1 in_valid = 1'b0;
        hold_valid = 0;
        scramble   = 1;
        repeat (3) @(negedge clk);
        chk("hold_accept_count", 32'(acc_cnt - acc0), 32'd1);
        chk("hold_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            op(ra, rb, rs, model(ra, rb, rs));
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        run8(8'hFF, 8'hFF, 1'b0, 9'h1FE);
        for (int i = 0; i < 8; i++) begin
            r8a = 8'($urandom);
            r8b = 8'($urandom);
            rs  = 1'($urandom);
            run8(r8a, r8b, rs, model8(r8a, r8b, rs));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_seq_adder.md
# chunked_seq_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's fixed-width ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the inter-chunk carry in a register, so a wide datapath reuses one narrow ripple slice. It sits between a valid/ready producer and consumer in the arithmetic datapath, trading latency for area.

## Interface
Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle, 1..WIDTH. N = WIDTH/CHUNK is the number of compute cycles.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand request valid.
- in_ready, output, 1: block can accept a request.
- a, input, WIDTH: first operand.
- b, input, WIDTH: second operand.
- sub, input, 1: 0 selects a+b; 1 selects a-b.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- sum, output, WIDTH+1: result; bit WIDTH is carry-out. For subtraction, bit WIDTH = 1 means no borrow.

## Operation
- Three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1 and out_valid=0. On in_valid&&in_ready, latch a, b^{WIDTH{sub}} and carry=sub, clear chunk index k to 0, and go to RUN.
- RUN: each cycle add chunk k of the latched a, chunk k of the latched b and the carry register with one CHUNK-bit ripple slice.
  - Write the result into bits [k*CHUNK +: CHUNK] of the result register.
  - Update the carry register with the slice carry-out and increment k.
  - After chunk N-1, write the final carry into sum[WIDTH] and go to DONE.
- DONE: out_valid=1 and in_ready=0. On out_ready go to IDLE. With out_ready low, stay in DONE and hold sum.
- Arithmetic is modulo 2^(WIDTH+1): sum = a + (sub ? ~b : b) + sub. No overflow flag.
- Operands are captured at acceptance. Changes on a, b or sub after that have no effect until the next acceptance.
- in_valid while not in IDLE is ignored; the producer must hold its request.
- in_ready is 0 in RUN and DONE, so acceptance and result delivery never occur in the same cycle.
- Reset at any time, including mid-RUN or in DONE, forces IDLE and clears the result, carry and k. The in-flight operation is discarded and no result is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0.
- Accept edge is cycle 0. RUN occupies cycles 1..N, and out_valid rises after the edge that ends cycle N.
- Latency from accept to first out_valid is N+1 cycles.
- Minimum initiation interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with immediate out_ready, then return to IDLE.
- sum is registered and stable for the whole time out_valid=1.
- sum may change during RUN (partial results); consumers sample it only when out_valid=1.
- CHUNK=WIDTH gives N=1: one RUN cycle, latency 2.

## Structure
- Shared package holds the state enum (IDLE, RUN, DONE) and a function for the index width, clog2(max(N,2)).
- One sub-module, `chunk_ripple_adder` (parameter CHUNK): purely combinational CHUNK-bit ripple slice with inputs a, b, ci and outputs sum[CHUNK-1:0], co. It is instantiated once.
- The top level holds the FSM, operand, result and carry registers, and the chunk mux/demux.

## Test plan
- WIDTH=16, CHUNK=4: add 0xFFFF+0x0001, out_ready=1 -> out_valid 5 cycles after accept, sum=0x10000, then in_ready returns high.
- Subtract 0x0005-0x0007 -> sum=0x0FFFE (borrow). Subtract 0x0007-0x0005 -> sum=0x10002.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid on 0x1234+0x4321 -> sum=0x05555 held stable and in_ready stays 0. Handshake on the 4th cycle -> IDLE.
- Assert reset in cycle 2 of RUN -> next cycle in_ready=1, out_valid=0, sum=0, and no result is ever produced. A new request 0x0001+0x0001 then yields 0x00002.
- Change a/b/sub during RUN -> result reflects the captured operands only. in_valid held high through RUN/DONE -> exactly one acceptance per transaction.
- Sweep configurations WIDTH=8/CHUNK=8 and WIDTH=8/CHUNK=1 -> 0xFF+0xFF=0x1FE with latencies 2 and 9; random compare against the reference model.
